regfile_access_ctrl: RTL and testbench

Initiator-side sequencer for the 16-bit, 32-entry register file in the non-pipelined MIPS datapath. It accepts decoded operand/destination indices from control over a valid/ready handshake, drives the register file's read port, and captures the registered read data. It then hands operands to the ALU, collects the result, and issues the write-back cycle. Reads and writes are never issued in the same cycle, because a register file write cycle blocks its read update.

---
 rtl/mips_rf_pkg.sv | 21 ++
 rtl/regfile_access_ctrl.sv | 162 ++++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_rf_pkg.sv
// Shared definitions for the register file access sequencer of the
// non-pipelined MIPS datapath: data/index widths, the sequencer state
// encoding and the hard-wired zero register index.
package mips_rf_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 5;

    // Register 0 is the MIPS $zero register
    localparam int ZERO_REG = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        EXEC    = 3'd3,
        RESULT  = 3'd4,
        WRITE   = 3'd5
    } rf_state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Initiator-side sequencer for the 32-entry register file.
// Accepts decoded operand/destination indices over a valid/ready handshake,
// issues a one-cycle read, captures the registered read data as ALU operands,
// collects the ALU result and issues a one-cycle write-back. Reads and writes
// never share a cycle, because a register file write blocks its read update.
// Optional build macro R0_PROTECT_EN: a write-back targeting register 0 is
// dropped and the instruction retires straight from RESULT.
module regfile_access_ctrl
    import mips_rf_pkg::*;
#(
    parameter int DATA_W = mips_rf_pkg::DATA_W,
    parameter int ADDR_W = mips_rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs,
    input  logic [ADDR_W-1:0] req_rt,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic              req_wb,

    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_reg_write,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,

    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,

    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,

    output logic              done
);

    rf_state_t         state;
    rf_state_t         state_next;

    logic [ADDR_W-1:0] rd_q;
    logic              wb_q;
    logic              skip_write;

    // An instruction retires from RESULT without a WRITE cycle when it has
    // nothing to write back (and, with register 0 protection, when it targets
    // register 0).
`ifdef R0_PROTECT_EN
    assign skip_write = !wb_q || (rd_q == ADDR_W'(ZERO_REG));
`else
    assign skip_write = !wb_q;
`endif

    // State register; reset drops any in-flight instruction immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded handshake / register file strobes.
    // done in RESULT also depends on res_valid so a no-write instruction
    // retires in the same cycle its result is accepted.
    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        op_valid     = 1'b0;
        res_ready    = 1'b0;
        rf_reg_write = 1'b0;
        done         = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = READ;
                end
            end
            READ: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = EXEC;
            end
            EXEC: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    if (skip_write) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                rf_reg_write = 1'b1;
                done         = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch: the read indices go straight onto the read port so they
    // are valid for the whole READ cycle and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_read_reg1 <= '0;
            rf_read_reg2 <= '0;
            rd_q         <= '0;
            wb_q         <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            rf_read_reg1 <= req_rs;
            rf_read_reg2 <= req_rt;
            rd_q         <= req_rd;
            wb_q         <= req_wb;
        end
    end

    // Operand capture: the register file has registered read data, so the
    // values requested in READ are sampled at the end of CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a <= '0;
            op_b <= '0;
        end else if (state == CAPTURE) begin
            op_a <= rf_read_data1;
            op_b <= rf_read_data2;
        end
    end

    // Result latch; the write port registers double as the result register and
    // are only loaded for instructions that really write, so they keep their
    // last written values at all other times.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else if (state == RESULT && res_valid && !skip_write) begin
            rf_write_reg  <= rd_q;
            rf_write_data <= res_data;
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Testbench for regfile_access_ctrl: a behavioural register file with
// registered reads (write cycles block the read update), a directed ALU
// handshake driver and a scoreboard of expected operands, write-backs and
// latencies. Honours R0_PROTECT_EN in the same way as the design.
module tb_regfile_access_ctrl;
    import mips_rf_pkg::*;

`ifdef R0_PROTECT_EN
    localparam bit PROTECT_R0 = 1'b1;
`else
    localparam bit PROTECT_R0 = 1'b0;
`endif

    typedef struct {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        bit                wr;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        int                latency;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_rs;
    logic [ADDR_W-1:0] req_rt;
    logic [ADDR_W-1:0] req_rd;
    logic              req_wb;
    logic [ADDR_W-1:0] rf_read_reg1;
    logic [ADDR_W-1:0] rf_read_reg2;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_reg_write;
    logic [DATA_W-1:0] rf_read_data1;
    logic [DATA_W-1:0] rf_read_data2;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              done;

    logic [DATA_W-1:0] rf_mem   [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] gold_reg [0:(1<<ADDR_W)-1];
    exp_t              sb_q [$];
    int                num_asserts = 0;
    int                num_fails   = 0;

    regfile_access_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rs        (req_rs),
        .req_rt        (req_rt),
        .req_rd        (req_rd),
        .req_wb        (req_wb),
        .rf_read_reg1  (rf_read_reg1),
        .rf_read_reg2  (rf_read_reg2),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_reg_write  (rf_reg_write),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .done          (done)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Register file model: preload, then registered reads that a write cycle blocks
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            rf_mem[i] = '0;
        end
        rf_mem[3] = 16'h0011;
        rf_mem[4] = 16'h0022;
        rf_read_data1 = '0;
        rf_read_data2 = '0;
        forever begin
            @(posedge clk);
            if (rf_reg_write) begin
                rf_mem[rf_write_reg] <= rf_write_data;
            end else begin
                rf_read_data1 <= rf_mem[rf_read_reg1];
                rf_read_data2 <= rf_mem[rf_read_reg2];
            end
        end
    end

    // One immediate-assertion comparison point
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_asserts++;
        assert (observed === expected)
        else begin
            num_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issue one instruction, play the ALU with the given stall counts, and
    // score operands, write-back and latency when it retires.
    // Called just after a falling edge with the controller idle.
    task automatic applyStimulus(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                                 input logic [ADDR_W-1:0] rd, input logic wb,
                                 input logic [DATA_W-1:0] res,
                                 input int op_wait, input int res_wait);
        exp_t              e;
        exp_t              got;
        int                cyc;
        int                op_cnt;
        int                res_cnt;
        int                wr_cnt;
        logic [ADDR_W-1:0] wr_reg;
        logic [DATA_W-1:0] wr_data;
        bit                got_done;
        bit                s_op_valid;
        bit                s_res_ready;

        e.wr      = wb && !(PROTECT_R0 && rd == ADDR_W'(ZERO_REG));
        e.a       = gold_reg[rs];
        e.b       = gold_reg[rt];
        e.rd      = rd;
        e.data    = res;
        e.latency = (e.wr ? 5 : 4) + op_wait + res_wait;
        if (e.wr) begin
            gold_reg[rd] = res;
        end
        sb_q.push_back(e);

        checkOutput("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_rs    = rs;
        req_rt    = rt;
        req_rd    = rd;
        req_wb    = wb;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_rs    = ~rs;
        req_rt    = ~rt;
        req_rd    = ~rd;
        req_wb    = ~wb;

        cyc      = 0;
        op_cnt   = 0;
        res_cnt  = 0;
        wr_cnt   = 0;
        wr_reg   = '0;
        wr_data  = '0;
        got_done = 1'b0;
        while (!got_done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            s_op_valid  = op_valid;
            s_res_ready = res_ready;
            if (s_op_valid) begin
                op_cnt++;
                checkOutput("op_a_stable", {16'd0, op_a}, {16'd0, e.a});
                checkOutput("op_b_stable", {16'd0, op_b}, {16'd0, e.b});
            end
            if (rf_reg_write) begin
                wr_cnt++;
                wr_reg  = rf_write_reg;
                wr_data = rf_write_data;
            end
            op_ready  = s_op_valid && (op_cnt > op_wait);
            if (s_res_ready) begin
                res_cnt++;
            end
            res_valid = s_res_ready && (res_cnt > res_wait);
            res_data  = res_valid ? res : 16'hDEAD;
            #1;
            if (done) begin
                got_done = 1'b1;
            end
        end
        checkOutput("done_seen", {31'd0, got_done}, 32'd1);

        got = sb_q.pop_front();
        checkOutput("latency", cyc, got.latency);
        checkOutput("write_count", wr_cnt, got.wr ? 32'd1 : 32'd0);
        if (got.wr) begin
            checkOutput("write_reg", {27'd0, wr_reg}, {27'd0, got.rd});
            checkOutput("write_data", {16'd0, wr_data}, {16'd0, got.data});
        end

        @(negedge clk);
        op_ready  = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        #1;
        checkOutput("req_ready_after_done", {31'd0, req_ready}, 32'd1);
        checkOutput("done_one_pulse", {31'd0, done}, 32'd0);
        checkOutput("no_write_after_done", {31'd0, rf_reg_write}, 32'd0);
    endtask

    // Directed sequence
    initial begin
        int cyc;

        for (int i = 0; i < (1 << ADDR_W); i++) begin
            gold_reg[i] = '0;
        end
        gold_reg[3] = 16'h0011;
        gold_reg[4] = 16'h0022;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_rs    = '0;
        req_rt    = '0;
        req_rd    = '0;
        req_wb    = 1'b0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;

        $display("[TB] reset state");
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_op_valid", {31'd0, op_valid}, 32'd0);
        checkOutput("rst_res_ready", {31'd0, res_ready}, 32'd0);
        checkOutput("rst_reg_write", {31'd0, rf_reg_write}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_op_a", {16'd0, op_a}, 32'd0);
        checkOutput("rst_op_b", {16'd0, op_b}, 32'd0);
        checkOutput("rst_read_reg1", {27'd0, rf_read_reg1}, 32'd0);
        checkOutput("rst_write_data", {16'd0, rf_write_data}, 32'd0);
        rst_n = 1'b1;
        #1;

        $display("[TB] add-style instruction with write-back");
        applyStimulus(5'd3, 5'd4, 5'd5, 1'b1, 16'h0033, 0, 0);

        $display("[TB] same instruction without write-back");
        applyStimulus(5'd3, 5'd4, 5'd5, 1'b0, 16'h0044, 0, 0);

        $display("[TB] ALU stalls: op_ready late 3, res_valid late 2");
        applyStimulus(5'd3, 5'd4, 5'd5, 1'b1, 16'h0033, 3, 2);

        $display("[TB] back-to-back write then dependent read");
        applyStimulus(5'd3, 5'd4, 5'd5, 1'b1, 16'h1234, 0, 0);
        applyStimulus(5'd5, 5'd3, 5'd6, 1'b0, 16'h0000, 0, 0);

        $display("[TB] reset during EXEC");
        req_rs    = 5'd3;
        req_rt    = 5'd4;
        req_rd    = 5'd9;
        req_wb    = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 0;
        while (!op_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("exec_reached", {31'd0, op_valid}, 32'd1);
        @(negedge clk);
        checkOutput("op_valid_held", {31'd0, op_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("exec_rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("exec_rst_op_valid", {31'd0, op_valid}, 32'd0);
        checkOutput("exec_rst_reg_write", {31'd0, rf_reg_write}, 32'd0);
        checkOutput("exec_rst_op_a", {16'd0, op_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        applyStimulus(5'd4, 5'd3, 5'd10, 1'b1, 16'h0F0F, 0, 0);

        $display("[TB] reset during WRITE");
        req_rs    = 5'd3;
        req_rt    = 5'd4;
        req_rd    = 5'd7;
        req_wb    = 1'b1;
        req_valid = 1'b1;
        op_ready  = 1'b1;
        res_valid = 1'b1;
        res_data  = 16'hABCD;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 0;
        while (!rf_reg_write && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("write_reached", {31'd0, rf_reg_write}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("wr_rst_reg_write", {31'd0, rf_reg_write}, 32'd0);
        checkOutput("wr_rst_done", {31'd0, done}, 32'd0);
        checkOutput("wr_rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("wr_rst_res_ready", {31'd0, res_ready}, 32'd0);
        op_ready  = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        applyStimulus(5'd7, 5'd4, 5'd8, 1'b0, 16'h5555, 0, 0);

        $display("[TB] write-back to register 0");
        applyStimulus(5'd3, 5'd4, 5'd0, 1'b1, 16'hFFFF, 0, 0);
        applyStimulus(5'd0, 5'd4, 5'd11, 1'b0, 16'h0001, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_asserts, num_fails);
        $finish;
    end

endmodule
